// File: rtl/console_scrollback_printer_if.sv
// Handshake bundle for console_scrollback_printer: line input from the PS/2
// line assembler, print control, and the character stream to the VGA writer.
interface console_scrollback_printer_if #(
    parameter int COLS   = 32,
    parameter int CHAR_W = 8,
    parameter int IDX_W  = 8
);
    logic [COLS*CHAR_W-1:0] line_data;
    logic                   line_valid;
    logic                   line_ready;
    logic                   start;
    logic                   busy;
    logic                   char_valid;
    logic [IDX_W-1:0]       char_index;
    logic [CHAR_W-1:0]      char_data;
    logic                   finish;

    modport master (
        output line_data, line_valid, start,
        input  line_ready, busy, char_valid, char_index, char_data, finish
    );

    modport slave (
        input  line_data, line_valid, start,
        output line_ready, busy, char_valid, char_index, char_data, finish
    );
endinterface

// File: rtl/console_scrollback_printer.sv
// Scrolling text console buffer that streams its visible window as index/data
// pairs. Optional macro CONSOLE_CLEAR_EN adds a 'clear' input that wipes the buffer in IDLE.
module console_scrollback_printer #(
    parameter int LINES      = 8,
    parameter int COLS       = 32,
    parameter int PRINT_COLS = 32,
    parameter int CHAR_W     = 8,
    parameter int IDX_W      = 8
) (
    input  logic clock,
    input  logic resetn,
`ifdef CONSOLE_CLEAR_EN
    input  logic clear,
`endif
    console_scrollback_printer_if.slave bus
);
    localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LINES - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PRINT_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRINT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CHAR_W-1:0]  mem_r [LINES][COLS];
    logic [ROW_W-1:0]   row_r;
    logic [ROW_W-1:0]   row_nxt_s;
    logic [COL_W-1:0]   col_r;
    logic [COL_W-1:0]   col_nxt_s;
    logic               clear_s;
    logic               wipe_s;
    logic               accept_s;
    logic               launch_s;
    logic               advance_s;
    logic               last_s;
    logic               finish_nxt_s;
    logic [CHAR_W-1:0]  first_char_s;
    logic [CHAR_W-1:0]  next_char_s;
    logic               char_valid_r;
    logic [IDX_W-1:0]   char_index_r;
    logic [CHAR_W-1:0]  char_data_r;
    logic               finish_r;

    function automatic logic [IDX_W-1:0] char_pos(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        int p;
        p = int'(r) * COLS + int'(c);
        return IDX_W'(p);
    endfunction

`ifdef CONSOLE_CLEAR_EN
    assign clear_s = clear;
`else
    assign clear_s = 1'b0;
`endif

    assign last_s      = (row_r == LAST_ROW) && (col_r == LAST_COL);
    assign next_char_s = mem_r[row_nxt_s][col_nxt_s];

    // The first character is loaded on the start edge, so it must see any same-edge scroll or wipe.
    always_comb begin
        first_char_s = mem_r[0][0];
        if (clear_s) begin
            first_char_s = {CHAR_W{1'b0}};
        end else if (bus.line_valid) begin
            first_char_s = mem_r[1][0];
        end else begin
            first_char_s = mem_r[0][0];
        end
    end

    // Position of the character that follows the one currently presented.
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (col_r == LAST_COL) begin
            col_nxt_s = {COL_W{1'b0}};
            row_nxt_s = row_r + ROW_ONE;
        end else begin
            col_nxt_s = col_r + COL_ONE;
            row_nxt_s = row_r;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s  = state_r;
        wipe_s       = 1'b0;
        accept_s     = 1'b0;
        launch_s     = 1'b0;
        advance_s    = 1'b0;
        finish_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wipe_s   = clear_s;
                accept_s = bus.line_valid & ~clear_s;
                if (bus.start) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ST_PRINT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRINT: begin
                if (last_s) begin
                    finish_nxt_s = 1'b1;
                    state_nxt_s  = ST_DONE;
                end else begin
                    advance_s    = 1'b1;
                    state_nxt_s  = ST_PRINT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Character store: wipe, or scroll up with the new line entering the bottom row.
    always_ff @(posedge clock) begin
        if (!resetn || wipe_s) begin
            for (int r = 0; r < LINES; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_r[r][c] <= {CHAR_W{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < LINES - 1; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_r[r][c] <= mem_r[r+1][c];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                mem_r[LINES-1][c] <= bus.line_data[(COLS-1-c)*CHAR_W +: CHAR_W];
            end
        end
    end

    // Print cursor and registered character stream; index/data hold when idle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            row_r        <= {ROW_W{1'b0}};
            col_r        <= {COL_W{1'b0}};
            char_valid_r <= 1'b0;
            char_index_r <= {IDX_W{1'b0}};
            char_data_r  <= {CHAR_W{1'b0}};
            finish_r     <= 1'b0;
        end else begin
            finish_r <= finish_nxt_s;
            if (launch_s) begin
                row_r        <= {ROW_W{1'b0}};
                col_r        <= {COL_W{1'b0}};
                char_valid_r <= 1'b1;
                char_index_r <= {IDX_W{1'b0}};
                char_data_r  <= first_char_s;
            end else if (advance_s) begin
                row_r        <= row_nxt_s;
                col_r        <= col_nxt_s;
                char_valid_r <= 1'b1;
                char_index_r <= char_pos(row_nxt_s, col_nxt_s);
                char_data_r  <= next_char_s;
            end else begin
                char_valid_r <= 1'b0;
            end
        end
    end

    assign bus.line_ready = (state_r == ST_IDLE);
    assign bus.busy       = (state_r == ST_PRINT);
    assign bus.char_valid = char_valid_r;
    assign bus.char_index = char_index_r;
    assign bus.char_data  = char_data_r;
    assign bus.finish     = finish_r;
endmodule

// File: tb/tb_console_scrollback_printer.sv
// Scoreboard bench: two printers (full-width and 11-column window) share one
// line stream; expected characters come from a list-of-lines reference model.
module tb_console_scrollback_printer;
    localparam int LINES  = 8;
    localparam int COLS   = 32;
    localparam int CHAR_W = 8;
    localparam int IDX_W  = 8;
    localparam int PC_A   = 32;
    localparam int PC_B   = 11;
    localparam int N_A    = LINES * PC_A;
    localparam int N_B    = LINES * PC_B;

    typedef logic [COLS*CHAR_W-1:0] line_t;
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [CHAR_W-1:0] data;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
`ifdef CONSOLE_CLEAR_EN
    logic clear  = 1'b0;
`endif
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    line_t model_lines[$];

    always #5 clock = ~clock;

    console_scrollback_printer_if #(.COLS(COLS), .CHAR_W(CHAR_W), .IDX_W(IDX_W)) ifa ();
    console_scrollback_printer_if #(.COLS(COLS), .CHAR_W(CHAR_W), .IDX_W(IDX_W)) ifb ();

    assign ifb.line_data  = ifa.line_data;
    assign ifb.line_valid = ifa.line_valid;
    assign ifb.start      = ifa.start;

    console_scrollback_printer #(.LINES(LINES), .COLS(COLS), .PRINT_COLS(PC_A),
                                 .CHAR_W(CHAR_W), .IDX_W(IDX_W)) dut_a (
        .clock  (clock),
        .resetn (resetn),
`ifdef CONSOLE_CLEAR_EN
        .clear  (clear),
`endif
        .bus    (ifa.slave)
    );

    console_scrollback_printer #(.LINES(LINES), .COLS(COLS), .PRINT_COLS(PC_B),
                                 .CHAR_W(CHAR_W), .IDX_W(IDX_W)) dut_b (
        .clock  (clock),
        .resetn (resetn),
`ifdef CONSOLE_CLEAR_EN
        .clear  (clear),
`endif
        .bus    (ifb.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the console is simply the last LINES lines received.
    function automatic logic [CHAR_W-1:0] model_char(input int r, input int c);
        line_t l;
        l = model_lines[r];
        return l[(COLS-1-c)*CHAR_W +: CHAR_W];
    endfunction

    task automatic model_reset();
        model_lines.delete();
        for (int i = 0; i < LINES; i++) model_lines.push_back('0);
    endtask

    task automatic model_accept(input line_t d);
        model_lines.push_back(d);
        void'(model_lines.pop_front());
    endtask

    task automatic push_expected();
        exp_t e;
        for (int r = 0; r < LINES; r++) begin
            for (int c = 0; c < COLS; c++) begin
                e.idx  = IDX_W'(r * COLS + c);
                e.data = model_char(r, c);
                if (c < PC_A) qa.push_back(e);
                if (c < PC_B) qb.push_back(e);
            end
        end
    endtask

    function automatic line_t fill_line(input logic [7:0] b);
        line_t l;
        for (int c = 0; c < COLS; c++) l[(COLS-1-c)*CHAR_W +: CHAR_W] = b;
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int c = 0; c < COLS; c++) l[(COLS-1-c)*CHAR_W +: CHAR_W] = 8'($urandom_range(1, 255));
        return l;
    endfunction

    // Monitors: every presented character is popped from its scoreboard queue.
    always @(negedge clock) begin
        if (ifa.char_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_char", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_char_index", 32'(ifa.char_index), 32'(e.idx));
                check("a_char_data", 32'(ifa.char_data), 32'(e.data));
            end
        end
    end

    always @(negedge clock) begin
        if (ifb.char_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_char", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_char_index", 32'(ifb.char_index), 32'(e.idx));
                check("b_char_data", 32'(ifb.char_data), 32'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        ifa.line_valid = 1'b0;
        ifa.start = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_a_valid", 32'(ifa.char_valid), 32'd0);
        check("rst_a_index", 32'(ifa.char_index), 32'd0);
        check("rst_a_data", 32'(ifa.char_data), 32'd0);
        check("rst_a_finish", 32'(ifa.finish), 32'd0);
        check("rst_a_busy", 32'(ifa.busy), 32'd0);
        check("rst_b_valid", 32'(ifb.char_valid), 32'd0);
        resetn = 1'b1;
        model_reset();
        qa.delete();
        qb.delete();
        @(negedge clock);
        check("rst_a_ready", 32'(ifa.line_ready), 32'd1);
        check("rst_b_ready", 32'(ifb.line_ready), 32'd1);
    endtask

    task automatic send_line(input line_t d);
        @(negedge clock);
        check("send_ready", 32'(ifa.line_ready), 32'd1);
        ifa.line_data  = d;
        ifa.line_valid = 1'b1;
        model_accept(d);
        @(negedge clock);
        ifa.line_valid = 1'b0;
    endtask

    // One print pass; optionally a line in the start cycle and an ignored line+start mid-pass.
    task automatic print_pass(input bit with_line, input line_t d, input int inject_at);
        @(negedge clock);
        if (with_line) begin
            ifa.line_data  = d;
            ifa.line_valid = 1'b1;
            model_accept(d);
        end
        ifa.start = 1'b1;
        push_expected();
        for (int k = 1; k <= N_A + 1; k++) begin
            @(negedge clock);
            ifa.start = 1'b0;
            ifa.line_valid = 1'b0;
            if (k == inject_at) begin
                ifa.line_data  = rand_line();
                ifa.line_valid = 1'b1;
                ifa.start      = 1'b1;
                check("a_ready_in_print", 32'(ifa.line_ready), 32'd0);
                check("b_ready_in_print", 32'(ifb.line_ready), 32'd0);
            end
            check("a_valid_timing", 32'(ifa.char_valid), 32'(k <= N_A));
            check("a_busy_timing", 32'(ifa.busy), 32'(k <= N_A));
            check("a_finish_timing", 32'(ifa.finish), 32'(k == N_A + 1));
            check("b_valid_timing", 32'(ifb.char_valid), 32'(k <= N_B));
            check("b_finish_timing", 32'(ifb.finish), 32'(k == N_B + 1));
        end
        @(negedge clock);
        check("a_back_idle", 32'(ifa.line_ready), 32'd1);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
    endtask

    task automatic abort_pass();
        @(negedge clock);
        ifa.start = 1'b1;
        push_expected();
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            ifa.start = 1'b0;
        end
        resetn = 1'b0;
        @(negedge clock);
        check("abort_a_valid", 32'(ifa.char_valid), 32'd0);
        check("abort_a_busy", 32'(ifa.busy), 32'd0);
        check("abort_b_valid", 32'(ifb.char_valid), 32'd0);
        resetn = 1'b1;
        model_reset();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("abort_a_no_finish", 32'(ifa.finish), 32'd0);
            check("abort_b_no_finish", 32'(ifb.finish), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_t l;
        ifa.line_data  = '0;
        ifa.line_valid = 1'b0;
        ifa.start      = 1'b0;
        do_reset();

        print_pass(1'b0, '0, 0);

        for (int c = 0; c < COLS; c++)
            l[(COLS-1-c)*CHAR_W +: CHAR_W] = (c < 26) ? 8'(8'h41 + c) : 8'(8'h30 + c - 26);
        send_line(l);
        print_pass(1'b0, '0, 0);

        for (int k = 1; k <= 9; k++) send_line(fill_line(8'(k)));
        print_pass(1'b0, '0, 0);

        for (int i = 0; i < 3; i++) send_line(rand_line());
        print_pass(1'b1, rand_line(), 50);
        print_pass(1'b0, '0, 0);

        send_line(rand_line());
        send_line(rand_line());
        abort_pass();
        print_pass(1'b0, '0, 0);

`ifdef CONSOLE_CLEAR_EN
        send_line(rand_line());
        send_line(rand_line());
        @(negedge clock);
        clear          = 1'b1;
        ifa.line_data  = rand_line();
        ifa.line_valid = 1'b1;
        model_reset();
        @(negedge clock);
        clear          = 1'b0;
        ifa.line_valid = 1'b0;
        print_pass(1'b0, '0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
